pc_sequencer: RTL

- Control FSM for the program counter.
- Decides each cycle whether the PC advances by 4, branches (PC+8 ± immediate, sign-magnitude), loads an absolute value (R15 write), or holds.
- Generates squash/issue qualifiers for the fetch/decode pipeline.
- Sits between decode/execute hazard logic and the PC register. Holding is done by driving the PC's write port with its own current value.

---
 rtl/pc_sequencer.sv | 117 +++++++++++
 1 files changed

// File: rtl/pc_sequencer.sv
// Program-counter control FSM: chooses advance/branch/load/hold and drives squash/issue.
// Optional performance counters are built when PC_SEQ_PERF_EN is defined.
module pc_sequencer #(
   parameter int unsigned FLUSH_CYCLES = 2,
   parameter int unsigned ADDR_W       = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              halt_req,
   input  logic              stall_req,
   input  logic              branch_req,
   input  logic [ADDR_W-1:0] branch_imm,
   input  logic              pc_write_req,
   input  logic [ADDR_W-1:0] pc_write_data,
   input  logic [ADDR_W-1:0] pc_curr,
   output logic              pc_branch,
   output logic [ADDR_W-1:0] pc_imm,
   output logic              pc_we,
   output logic [ADDR_W-1:0] pc_wdata,
   output logic              squash,
   output logic              issue_valid,
   output logic              halted,
   output logic [1:0]        state_o,
   output logic [15:0]       branch_count,
   output logic [15:0]       stall_count
);

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StRun   = 2'd1,
      StFlush = 2'd2,
      StHalt  = 2'd3
   } state_t;

   localparam logic [3:0] FlushInit = 4'(FLUSH_CYCLES);

   state_t     state;
   logic [3:0] flush_cnt;
   logic       redirect;
   logic       load_req;
   logic       stall_evt;

   assign redirect  = ((state == StRun) || (state == StFlush)) && (pc_write_req || branch_req);
   // Absolute load beats a branch when both arrive together.
   assign load_req  = redirect && pc_write_req;
   assign stall_evt = (state == StRun) && stall_req && !redirect;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= StIdle;
         flush_cnt <= 4'd0;
      end else begin
         unique case (state)
            StIdle: begin
               if (start) state <= StRun;
            end
            StRun: begin
               if (redirect) begin
                  state     <= StFlush;
                  flush_cnt <= FlushInit;
               end else if (halt_req) begin
                  state <= StHalt;
               end
            end
            StFlush: begin
               if (redirect) begin
                  flush_cnt <= FlushInit;
               end else if (flush_cnt <= 4'd1) begin
                  state     <= StRun;
                  flush_cnt <= 4'd0;
               end else begin
                  flush_cnt <= flush_cnt - 4'd1;
               end
            end
            StHalt: begin
               if (start) state <= StRun;
            end
            default: state <= StIdle;
         endcase
      end
   end

   // Holding the PC means rewriting it with its own value.
   always_comb begin
      pc_branch   = redirect && branch_req && !pc_write_req;
      pc_imm      = branch_imm;
      pc_we       = load_req || (state == StIdle) || (state == StHalt) || stall_evt;
      pc_wdata    = load_req ? pc_write_data : pc_curr;
      squash      = redirect || (state == StFlush);
      issue_valid = (state == StRun) && !stall_req && !redirect;
      halted      = (state == StHalt);
      state_o     = state;
   end

`ifdef PC_SEQ_PERF_EN
   logic [15:0] branch_cnt_q;
   logic [15:0] stall_cnt_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         branch_cnt_q <= 16'd0;
         stall_cnt_q  <= 16'd0;
      end else begin
         if (redirect && (branch_cnt_q != 16'hFFFF)) branch_cnt_q <= branch_cnt_q + 16'd1;
         if (stall_evt && (stall_cnt_q != 16'hFFFF)) stall_cnt_q <= stall_cnt_q + 16'd1;
      end
   end

   assign branch_count = branch_cnt_q;
   assign stall_count  = stall_cnt_q;
`else
   assign branch_count = 16'd0;
   assign stall_count  = 16'd0;
`endif

endmodule
